// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling from a per-bit counter,
// and a one-deep holding register with a ready/acknowledge handshake.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int unsigned CNT_W        = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic             start_edge;
  logic             load_byte;
  logic             stop_bad;

  assign start_edge = ~rx_s_q & rx_prev_q;

  // State register, datapath and synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load_byte = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A high line at mid-start means the falling edge was a glitch.
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            load_byte = 1'b1;
            state_d   = StIdle;
          end else begin
            stop_bad = 1'b1;
            state_d  = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitIdle: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_ready_d  = rx_ready_q;
    overrun_d   = overrun_q;
    frame_err_d = stop_bad;
    if (load_byte) begin
      // A load wins over a same-cycle acknowledge; that ack consumes the old byte.
      rx_data_d  = shift_q;
      rx_ready_d = 1'b1;
      overrun_d  = rx_ready_q & ~rd_ack;
    end else if (rd_ack && rx_ready_q) begin
      rx_ready_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_ready  = rx_ready_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized bench for uart_rx_byte: a timing model built from absolute sample instants
// is compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int ACK_AT_LOAD = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, overrun, frame_err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  bit cmp_en = 1'b0;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF),
    .CNT_W       (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rd_ack   (rd_ack),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the line seen by the receiver is rx delayed two edges; after a falling edge at
  // edge t0 the line is read at t0+HALF (start), t0+HALF+k*CPB (data k=1..8), t0+HALF+9*CPB.
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_prev = 1'b1;
  int         m_cyc = 0;
  int         m_mode = 0;  // 0 idle, 1 in frame, 2 waiting for high line
  int         m_t0 = 0;
  logic [7:0] m_shift = 8'h00, m_data = 8'h00;
  logic       m_ready = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1;
      m_mode = 0; m_shift = 8'h00; m_data = 8'h00;
      m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    end else begin
      logic s, ld;
      int d;
      m_cyc++;
      s = m_s2;
      ld = 1'b0;
      m_fe = 1'b0;
      if (m_mode == 0) begin
        if (!s && m_prev) begin
          m_mode = 1;
          m_t0 = m_cyc;
        end
      end else if (m_mode == 2) begin
        if (s) m_mode = 0;
      end else begin
        d = m_cyc - m_t0;
        if (d == HALF) begin
          if (s) m_mode = 0;
        end else if (d > HALF && d < HALF + 9 * CPB && (d - HALF) % CPB == 0) begin
          m_shift[(d - HALF) / CPB - 1] = s;
        end else if (d == HALF + 9 * CPB) begin
          if (s) begin
            ld = 1'b1;
            m_mode = 0;
          end else begin
            m_fe = 1'b1;
            m_mode = 2;
          end
        end
      end
      if (ld) begin
        m_data = m_shift;
        m_ovr = m_ready && !rd_ack;
        m_ready = 1'b1;
      end else if (rd_ack && m_ready) begin
        m_ready = 1'b0;
        m_ovr = 1'b0;
      end
      m_prev = m_s2;
      m_s2 = m_s1;
      m_s1 = rx;
    end
  end

  always @(posedge clk) begin
    #1;
    if (frame_err) fe_cnt++;
    if (cmp_en) begin
      check8("rx_data", rx_data, m_data);
      check1("rx_ready", rx_ready, m_ready);
      check1("overrun", overrun, m_ovr);
      check1("frame_err", frame_err, m_fe);
      check1("busy", busy, m_mode != 0);
    end
  end

  task automatic idle(input int n, input bit rnd_ack);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
      rd_ack = rnd_ack && ($urandom_range(0, 29) == 0);
    end
  endtask

  // Stop bit is held low for stop_low bit times when stop_low > 0.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int ack_at,
                            input bit rnd_ack);
    int nbits;
    int j;
    nbits = 9 + ((stop_low > 0) ? stop_low : 1);
    for (int i = 0; i < nbits * CPB; i++) begin
      @(negedge clk);
      j = i / CPB;
      if (j == 0) rx = 1'b0;
      else if (j <= 8) rx = b[j-1];
      else rx = (stop_low > 0) ? 1'b0 : 1'b1;
      rd_ack = (i == ack_at) || (rnd_ack && ($urandom_range(0, 29) == 0));
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  initial begin
    int fe_base;
    int kind;
    repeat (3) @(negedge clk);
    check8("reset rx_data", rx_data, 8'h00);
    check1("reset rx_ready", rx_ready, 1'b0);
    check1("reset overrun", overrun, 1'b0);
    check1("reset frame_err", frame_err, 1'b0);
    check1("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(20, 1'b0);

    fe_base = fe_cnt;
    send_frame(8'hA5, 0, -1, 1'b0);
    check8("a5 data", rx_data, 8'hA5);
    check1("a5 ready", rx_ready, 1'b1);
    check1("a5 overrun", overrun, 1'b0);
    check1("a5 busy", busy, 1'b0);
    check8("a5 no frame_err", 8'(fe_cnt - fe_base), 8'd0);

    idle(5, 1'b0);
    send_frame(8'h3C, 0, -1, 1'b0);
    check8("3c data", rx_data, 8'h3C);
    check1("3c overrun", overrun, 1'b1);
    check1("3c ready", rx_ready, 1'b1);
    pulse_ack();
    check1("ack ready", rx_ready, 1'b0);
    check1("ack overrun", overrun, 1'b0);

    fe_base = fe_cnt;
    send_frame(8'h55, 3, -1, 1'b0);
    check1("bad stop busy", busy, 1'b1);
    check8("bad stop one pulse", 8'(fe_cnt - fe_base), 8'd1);
    check8("bad stop data kept", rx_data, 8'h3C);
    check1("bad stop no ready", rx_ready, 1'b0);
    idle(10, 1'b0);
    check1("wait released", busy, 1'b0);
    send_frame(8'h0F, 0, -1, 1'b0);
    check8("0f data", rx_data, 8'h0F);
    pulse_ack();

    fe_base = fe_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(20, 1'b0);
    check1("glitch ready", rx_ready, 1'b0);
    check1("glitch busy", busy, 1'b0);
    check8("glitch frame_err", 8'(fe_cnt - fe_base), 8'd0);

    send_frame(8'h77, 0, -1, 1'b0);
    idle(3, 1'b0);
    send_frame(8'h81, 0, ACK_AT_LOAD, 1'b0);
    check1("ack on load ready", rx_ready, 1'b1);
    check8("ack on load data", rx_data, 8'h81);
    check1("ack on load overrun", overrun, 1'b0);

    idle(3, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check8("midframe reset data", rx_data, 8'h00);
    check1("midframe reset ready", rx_ready, 1'b0);
    check1("midframe reset busy", busy, 1'b0);
    check1("midframe reset frame_err", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10, 1'b0);
    send_frame(8'h12, 0, -1, 1'b0);
    check8("12 data", rx_data, 8'h12);
    check1("12 ready", rx_ready, 1'b1);

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        for (int i = 0; i < $urandom_range(1, 6); i++) begin
          @(negedge clk);
          rx = 1'b0;
        end
      end else if (kind == 1) begin
        send_frame(8'($urandom), $urandom_range(1, 2), -1, 1'b1);
      end else begin
        send_frame(8'($urandom), 0, -1, 1'b1);
      end
      idle($urandom_range(0, 30), 1'b1);
    end
    idle(40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
